// File: rtl/sdram_host_arbiter_if.sv
// Requester and SDRAM-controller host signals shared by sdram_host_arbiter.
// master = requesters plus controller side, slave = the arbiter.
interface sdram_host_arbiter_if #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned HADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH  = 16
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ*HADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_rdata;
  logic                           ctrl_rd_enable;
  logic                           ctrl_wr_enable;
  logic [HADDR_WIDTH-1:0]         ctrl_addr;
  logic [DATA_WIDTH-1:0]          ctrl_wdata;
  logic [DATA_WIDTH-1:0]          ctrl_rd_data;
  logic                           ctrl_rd_ready;
  logic [4:0]                     ctrl_state;
  logic                           proto_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output ctrl_rd_data, ctrl_rd_ready, ctrl_state,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ctrl_rd_enable, ctrl_wr_enable, ctrl_addr, ctrl_wdata, proto_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  ctrl_rd_data, ctrl_rd_ready, ctrl_state,
    output req_ready, rsp_valid, rsp_rdata,
    output ctrl_rd_enable, ctrl_wr_enable, ctrl_addr, ctrl_wdata, proto_err
  );
endinterface

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller host port among NUM_REQ requesters.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module sdram_host_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned HADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  sdram_host_arbiter_if.slave bus
);
  localparam int unsigned PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0]  CS_IDLE     = 5'h00;
  localparam logic [4:0]  CS_READ_ACT = 5'h10;
  localparam logic [4:0]  CS_WRIT_ACT = 5'h18;

  typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_RUN} state_t;

  state_t                  r_state,       w_state_nxt;
  logic [NUM_REQ-1:0]      r_gnt,         w_gnt_nxt;
  logic                    r_we,          w_we_nxt;
  logic [NUM_REQ-1:0]      r_req_ready,   w_req_ready_nxt;
  logic [NUM_REQ-1:0]      r_rsp_valid,   w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
  logic                    r_rd_en,       w_rd_en_nxt;
  logic                    r_wr_en,       w_wr_en_nxt;
  logic [HADDR_WIDTH-1:0]  r_addr,        w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata,       w_wdata_nxt;
  logic                    r_proto_err,   w_proto_err_nxt;
  logic                    w_found;
  logic [PTR_W-1:0]        w_gidx;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]        r_rr,          w_rr_nxt;
`endif

  // Winner search; scanning downward lets the highest-priority candidate overwrite last.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'(i);
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[(32'(r_rr) + 32'(i)) % NUM_REQ]) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'((32'(r_rr) + 32'(i)) % NUM_REQ);
      end
    end
`endif
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_we_nxt        = r_we;
    w_req_ready_nxt = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rd_en_nxt     = r_rd_en;
    w_wr_en_nxt     = r_wr_en;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_proto_err_nxt = r_proto_err;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    w_rr_nxt        = r_rr;
`endif
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_gnt_nxt       = NUM_REQ'(1) << w_gidx;
          w_req_ready_nxt = NUM_REQ'(1) << w_gidx;
          w_we_nxt        = bus.req_we[w_gidx];
          w_addr_nxt      = bus.req_addr[32'(w_gidx)*HADDR_WIDTH +: HADDR_WIDTH];
          w_wdata_nxt     = bus.req_wdata[32'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
          w_rd_en_nxt     = ~bus.req_we[w_gidx];
          w_wr_en_nxt     = bus.req_we[w_gidx];
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          w_rr_nxt        = PTR_W'((32'(w_gidx) + 32'd1) % NUM_REQ);
`endif
          w_state_nxt     = ST_ISSUE;
        end
      end
      // Enable is ignored during init/refresh/busy, so hold it until the matching ACT.
      ST_ISSUE: begin
        if ((r_we && bus.ctrl_state == CS_WRIT_ACT) ||
            (!r_we && bus.ctrl_state == CS_READ_ACT)) begin
          w_rd_en_nxt = 1'b0;
          w_wr_en_nxt = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.ctrl_state == CS_IDLE) begin
          if (!r_we) begin
            w_rsp_rdata_nxt = bus.ctrl_rd_data;
            if (!bus.ctrl_rd_ready) w_proto_err_nxt = 1'b1;
          end
          w_rsp_valid_nxt = r_gnt;
          w_state_nxt     = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_gnt       <= '0;
      r_we        <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_proto_err <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      r_rr        <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_we        <= w_we_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_proto_err <= w_proto_err_nxt;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      r_rr        <= w_rr_nxt;
`endif
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.ctrl_rd_enable = r_rd_en;
  assign bus.ctrl_wr_enable = r_wr_en;
  assign bus.ctrl_addr      = r_addr;
  assign bus.ctrl_wdata     = r_wdata;
  assign bus.proto_err      = r_proto_err;
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Scoreboard bench for sdram_host_arbiter with a small behavioural SDRAM controller model.
module tb_sdram_host_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;

  localparam logic [4:0] S_IDLE    = 5'h00;
  localparam logic [4:0] S_INIT    = 5'h01;
  localparam logic [4:0] S_REF_PRE = 5'h08;
  localparam logic [4:0] S_REF_REF = 5'h09;
  localparam logic [4:0] S_RD_ACT  = 5'h10;
  localparam logic [4:0] S_RD_NOP  = 5'h11;
  localparam logic [4:0] S_RD_CAS  = 5'h12;
  localparam logic [4:0] S_WR_ACT  = 5'h18;
  localparam logic [4:0] S_WR_NOP1 = 5'h19;
  localparam logic [4:0] S_WR_NOP2 = 5'h1B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_host_arbiter_if #(.NUM_REQ(NR), .HADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_host_arbiter #(.NUM_REQ(NR), .HADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller model
  logic [4:0]  m_state;
  int          m_cnt;
  logic        m_rdy;
  logic [15:0] m_rdata;
  logic [23:0] m_addr, m_wr_addr;
  logic [15:0] m_wr_data;
  bit          m_drop = 1'b0;
  int          ref_go = 0, ref_seen = 0, init_go = 0, init_seen = 0;

  function automatic logic [15:0] lookup(input logic [23:0] a);
    if (a == 24'h00ABCD) return 16'hBEEF;
    if (a == m_wr_addr)  return m_wr_data;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state   <= S_IDLE;
      m_cnt     <= 0;
      m_rdy     <= 1'b0;
      m_rdata   <= '0;
      m_addr    <= '0;
      m_wr_addr <= 24'hFFFFFF;
      m_wr_data <= '0;
      ref_seen  <= ref_go;
      init_seen <= init_go;
    end else begin
      m_rdy <= 1'b0;
      case (m_state)
        S_IDLE: begin
          if (init_go != init_seen) begin
            init_seen <= init_go; m_state <= S_INIT; m_cnt <= 8;
          end else if (ref_go != ref_seen) begin
            ref_seen <= ref_go; m_state <= S_REF_PRE; m_cnt <= 6;
          end else if (bus.ctrl_rd_enable) begin
            m_addr <= bus.ctrl_addr; m_state <= S_RD_ACT;
          end else if (bus.ctrl_wr_enable) begin
            m_wr_addr <= bus.ctrl_addr; m_wr_data <= bus.ctrl_wdata; m_state <= S_WR_ACT;
          end
        end
        S_INIT:    if (m_cnt == 0) m_state <= S_IDLE; else m_cnt <= m_cnt - 1;
        S_REF_PRE: m_state <= S_REF_REF;
        S_REF_REF: if (m_cnt == 0) m_state <= S_IDLE; else m_cnt <= m_cnt - 1;
        S_RD_ACT:  m_state <= S_RD_NOP;
        S_RD_NOP:  m_state <= S_RD_CAS;
        S_RD_CAS: begin
          m_state <= S_IDLE;
          m_rdy   <= !m_drop;
          m_rdata <= lookup(m_addr);
        end
        S_WR_ACT:  m_state <= S_WR_NOP1;
        S_WR_NOP1: m_state <= S_WR_NOP2;
        S_WR_NOP2: m_state <= S_IDLE;
        default:   m_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl_state    = m_state;
  assign bus.ctrl_rd_ready = m_rdy;
  assign bus.ctrl_rd_data  = m_rdata;

  // Scoreboard queues and monitor
  typedef struct {
    int          idx;
    logic [15:0] rdata;
    bit          pe;
  } exp_t;

  exp_t rsp_q[$];
  int   gnt_q[$];
  exp_t mon_e;
  int   mon_g;

  task automatic push_rsp(input int idx, input logic [15:0] rdata, input bit pe);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.pe = pe;
    rsp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (|bus.req_ready) begin
        if (gnt_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_grant: req_ready=%b with none expected", bus.req_ready);
        end else begin
          mon_g = gnt_q.pop_front();
          chk("grant", 32'(bus.req_ready), 32'(1) << mon_g);
        end
      end
      if (|bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with none expected", bus.rsp_valid);
        end else begin
          mon_e = rsp_q.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << mon_e.idx);
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.rdata));
          chk("proto_err", 32'(bus.proto_err), 32'(mon_e.pe));
        end
      end
    end
  end

  task automatic check_rst(input string name);
    chk({name, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({name, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'h0);
    chk({name, "_rd_en"},     32'(bus.ctrl_rd_enable), 32'h0);
    chk({name, "_wr_en"},     32'(bus.ctrl_wr_enable), 32'h0);
    chk({name, "_addr"},      32'(bus.ctrl_addr), 32'h0);
    chk({name, "_wdata"},     32'(bus.ctrl_wdata), 32'h0);
    chk({name, "_proto_err"}, 32'(bus.proto_err), 32'h0);
  endtask

  // Present one request (called at a negedge); returns at the negedge req_ready is seen.
  task automatic do_req(input int idx, input bit we, input logic [23:0] addr,
                        input logic [15:0] wd, input bit push, input logic [15:0] exp_rd,
                        input bit exp_pe, input bit chk_lat);
    int cyc;
    gnt_q.push_back(idx);
    if (push) push_rsp(idx, exp_rd, exp_pe);
    bus.req_addr[idx*AW +: AW]  = addr;
    bus.req_wdata[idx*DW +: DW] = wd;
    bus.req_we[idx]             = we;
    bus.req_valid[idx]          = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.req_ready[idx] && cyc < 200);
    if (!bus.req_ready[idx]) begin
      n_chk++; n_err++;
      $display("FAIL req_timeout: req%0d got no req_ready within %0d cycles", idx, cyc);
    end else if (chk_lat) begin
      chk("req_latency", 32'(cyc), 32'd1);
    end
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (rsp_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (rsp_q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL rsp_timeout: %0d responses still pending, need 0", rsp_q.size());
      rsp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_mstate(input logic [4:0] s, input string name);
    int cyc = 0;
    while (m_state != s && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (m_state != s) begin
      n_chk++; n_err++;
      $display("FAIL %s: controller state %h never reached %h", name, m_state, s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int exp_g[4];
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single read
    do_req(0, 1'b0, 24'h00ABCD, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("t1_rd_en", 32'(bus.ctrl_rd_enable), 32'h1);
    chk("t1_addr", 32'(bus.ctrl_addr), 32'h00ABCD);
    wait_mstate(S_RD_ACT, "t1_act");
    chk("t1_rd_en_at_act", 32'(bus.ctrl_rd_enable), 32'h1);
    @(negedge clk);
    chk("t1_rd_en_dropped", 32'(bus.ctrl_rd_enable), 32'h0);
    wait_drain();

    // 2: write issued while the controller refreshes
    ref_go++;
    do_req(1, 1'b1, 24'h000010, 16'h1234, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("t2_wdata", 32'(bus.ctrl_wdata), 32'h1234);
    cyc = 0;
    while (m_state != S_IDLE && cyc < 50) begin
      chk("t2_wr_en_in_refresh", 32'(bus.ctrl_wr_enable), 32'h1);
      @(negedge clk);
      cyc++;
    end
    wait_drain();

    // 3: contention, both held for four accesses
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(exp_g[k]);
      push_rsp(exp_g[k], (exp_g[k] == 0) ? 16'h5B5A : 16'h585A, 1'b0);
    end
    bus.req_addr  = {24'h000200, 24'h000100};
    bus.req_we    = 2'b00;
    bus.req_valid = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (|bus.req_ready) n++;
    end
    bus.req_valid = 2'b00;
    if (n < 4) begin
      n_chk++; n_err++;
      $display("FAIL t3_grants: saw %0d grants, need 4", n);
    end
    wait_drain();

    // 4: request during controller init
    init_go++;
    do_req(0, 1'b0, 24'h000010, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
    cyc = 0;
    while (m_state == S_INIT && cyc < 50) begin
      chk("t4_rd_en_in_init", 32'(bus.ctrl_rd_enable), 32'h1);
      chk("t4_no_rsp_in_init", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      cyc++;
    end
    wait_drain();

    // 5: read finishes without rd_ready; error is sticky
    m_drop = 1'b1;
    do_req(1, 1'b0, 24'h000300, 16'h0000, 1'b1, 16'h595A, 1'b1, 1'b0);
    wait_drain();
    m_drop = 1'b0;
    chk("t5_proto_err_sticky", 32'(bus.proto_err), 32'h1);
    do_req(0, 1'b0, 24'h00ABCD, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    wait_drain();

    // 6a: reset while stalled in ISSUE
    ref_go++;
    do_req(0, 1'b0, 24'h000400, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_rd_en_before_rst", 32'(bus.ctrl_rd_enable), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_rst("t6_issue_rst");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 6b: reset while waiting for the read to finish
    do_req(0, 1'b0, 24'h000500, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    wait_mstate(S_RD_NOP, "t6_run");
    rst = 1'b1;
    @(negedge clk);
    check_rst("t6_run_rst");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // rr pointer restarts at 0 after reset
    gnt_q.push_back(0);
    push_rsp(0, 16'h5B5A, 1'b0);
    bus.req_addr  = {24'h000200, 24'h000100};
    bus.req_we    = 2'b00;
    bus.req_valid = 2'b11;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(|bus.req_ready) && cyc < 50);
    bus.req_valid = 2'b00;
    if (!(|bus.req_ready)) begin
      n_chk++; n_err++;
      $display("FAIL t6_post_rst_grant: no req_ready within %0d cycles", cyc);
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
